mmio_input_port: RTL and testbench
==================================

# mmio_input_port

Memory-mapped input responder for the RISC machine. It synchronises and debounces the board's slide switches and push buttons, latches button-press events, and answers CPU read requests on the memory bus with the current switch and key state. It sits beside the data RAM on the CPU's mem_cmd/mem_addr bus and is the input counterpart of the hex/LED output path.

## Interface
- DEBOUNCE_CYCLES, 500000: cycles a synchronised input must hold a new value before it is accepted (10 ms at 50 MHz); minimum 2.
- SW_ADDR, 9'h140: read address returning switch state.
- KEY_ADDR, 9'h141: read address returning key level and event bits.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- SW  input  10  raw slide switches, asynchronous to clk.
- KEY  input  4  raw push buttons, active-low (0 = pressed), asynchronous to clk.
- mem_cmd  input  2  bus command: MNONE / MREAD / MWRITE.
- mem_addr  input  9  bus address.
- rd_data  output  16  registered read data; 16'h0000 when not responding, so it can be OR-ed onto the bus.
- rd_valid  output  1  high for one cycle when rd_data carries a response.

## Operation
- Synchroniser: two flops per input bit. Reset values: SW stages 0, KEY stages 1 (released).
- Debounce per bit, with a counter of width $clog2(DEBOUNCE_CYCLES):
  - synced == stable: counter cleared.
  - synced != stable: counter increments; on the cycle the counter equals DEBOUNCE_CYCLES-1, stable <= synced and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES restarts the count and never reaches stable.
- Key level is exposed active-high: key_level = ~stable_key.
- key_event[i] is sticky. It sets on the same edge that key_level[i] rises 0→1. Release sets nothing.
- Read decode, with mem_cmd == MREAD sampled at edge t:
  - mem_addr == SW_ADDR: rd_data = {6'b0, sw_stable[9:0]}, rd_valid = 1.
  - mem_addr == KEY_ADDR: rd_data = {8'b0, key_level[3:0], key_event[3:0]}, rd_valid = 1; key_event clears at edge t (read-to-clear).
  - Any other address or command: rd_data = 0, rd_valid = 0.
- MWRITE to either address is ignored and has no side effects.
- Simultaneous set and clear on the same bit at edge t: set wins. The bit stays 1, the read at t returns the pre-edge value 0, and the next read reports 1.
- Reset outputs: rd_data = 0, rd_valid = 0. Reset state: sw_stable = 0, key_level = 0, key_event = 0, all counters 0.
- Reset asserted mid-debounce or mid-read discards the count and any pending response on that edge.

## Timing
- Read latency: 1 cycle. A request sampled at edge t appears on rd_data/rd_valid after edge t and holds for exactly one cycle.
- Back-to-back reads on consecutive cycles are supported, one response per cycle.
- Input latency, raw change to stable/key_level: 2 + DEBOUNCE_CYCLES cycles, provided the raw input holds.
- key_event is visible to a read issued on the cycle after key_level rises.

## Configuration
- INPUT_PORT_EVENT_EN defined: sticky key_event latch and read-to-clear are present.
- INPUT_PORT_EVENT_EN undefined: no event flops or edge logic. KEY_ADDR returns {8'b0, key_level, 4'b0000], reads have no side effects, and level and switch behaviour are unchanged.

## Structure
- Shared package (alongside the CPU's): mem_cmd encodings MNONE = 2'b00, MREAD = 2'b01, MWRITE = 2'b10; the address constants 9'h140 and 9'h141 used as parameter defaults.
- One sub-module: debounce_bit. It contains the two-flop synchroniser, counter and stable flop, parameterised by DEBOUNCE_CYCLES and a reset value.
- The top instantiates debounce_bit 14 times; decode, event and read-register logic live in the top.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset, then read SW_ADDR with SW = 10'h3FF held less than 6 cycles → rd_data 16'h0000; after 6+ cycles, read → 16'h03FF with rd_valid exactly one cycle.
- SW[0] pulses high for 3 cycles → next read of SW_ADDR returns 16'h0000 (glitch rejected).
- KEY[2] held 0 for 10 cycles, read KEY_ADDR → 16'h0044; immediate second read → 16'h0040 (event cleared, level held).
- Read KEY_ADDR on the exact edge key_level[1] rises → returns 16'h0000 (pre-edge value); next read → 16'h0022.
- MWRITE to KEY_ADDR while key_event = 4'h1 → no rd_valid; following read still returns the event bit set.
- Assert reset mid-read and mid-debounce → rd_valid 0 and rd_data 0 next cycle; key_event, key_level and sw_stable are 0.

Source files
------------

// File: rtl/mmio_input_port_pkg.sv
// Shared bus definitions for the memory-mapped input responder: bus command
// encodings, default register addresses and a small address-decode helper.
package mmio_input_port_pkg;

    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10
    } mem_cmd_e;

    localparam logic [8:0] SW_ADDR_DEF  = 9'h140;
    localparam logic [8:0] KEY_ADDR_DEF = 9'h141;

    // Only MREAD is answered; MWRITE to these addresses is deliberately inert.
    function automatic logic is_read_of(input logic [1:0] cmd,
                                        input logic [8:0] addr,
                                        input logic [8:0] target);
        return (cmd == MREAD) && (addr == target);
    endfunction

endpackage

// File: rtl/mmio_input_port_if.sv
// CPU memory-bus slice seen by the input port: command/address towards the
// port, registered read data and valid back to the CPU.
interface mmio_input_port_if;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] rd_data;
    logic        rd_valid;

    modport master (
        output mem_cmd,
        output mem_addr,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/mmio_input_port_debounce_bit.sv
// One input bit: two-flop synchroniser followed by a hold-time debouncer.
// stable_next exposes the value stable takes on the coming edge.
module debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic stable_next
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_reg;
    logic             sync_reg;
    logic             stable_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Any return to the stable value restarts the hold count from zero.
    always_comb begin
        cnt_next    = '0;
        stable_next = stable_reg;
        if (sync_reg != stable_reg) begin
            if (cnt_reg == CNT_LAST) begin
                stable_next = sync_reg;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg   <= RESET_VAL;
            sync_reg   <= RESET_VAL;
            stable_reg <= RESET_VAL;
            cnt_reg    <= '0;
        end else begin
            meta_reg   <= raw;
            sync_reg   <= meta_reg;
            stable_reg <= stable_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign stable = stable_reg;

endmodule

// File: rtl/mmio_input_port.sv
// Memory-mapped switch/key input port with one-cycle registered reads.
// Define INPUT_PORT_EVENT_EN to add sticky, read-to-clear key press events.
module mmio_input_port
    import mmio_input_port_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter logic [8:0] SW_ADDR         = SW_ADDR_DEF,
    parameter logic [8:0] KEY_ADDR        = KEY_ADDR_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           SW,
    input  logic [3:0]           KEY,
    mmio_input_port_if.slave     bus
);

    logic [9:0]  sw_stable;
    logic [9:0]  sw_stable_next;
    logic [3:0]  key_stable;
    logic [3:0]  key_stable_next;
    logic [3:0]  key_level;
    logic [3:0]  key_event_bits;
    logic        rd_sw;
    logic        rd_key;
    logic [15:0] rd_data_reg;
    logic [15:0] rd_data_next;
    logic        rd_valid_reg;
    logic        rd_valid_next;

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_sw
            debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .RESET_VAL      (1'b0)
            ) u_db (
                .clk        (clk),
                .reset      (reset),
                .raw        (SW[gi]),
                .stable     (sw_stable[gi]),
                .stable_next(sw_stable_next[gi])
            );
        end
        // Keys idle high, so their synchronisers reset to "released".
        for (gi = 0; gi < 4; gi++) begin : g_key
            debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .RESET_VAL      (1'b1)
            ) u_db (
                .clk        (clk),
                .reset      (reset),
                .raw        (KEY[gi]),
                .stable     (key_stable[gi]),
                .stable_next(key_stable_next[gi])
            );
        end
    endgenerate

    assign key_level = ~key_stable;
    assign rd_sw     = is_read_of(bus.mem_cmd, bus.mem_addr, SW_ADDR);
    assign rd_key    = is_read_of(bus.mem_cmd, bus.mem_addr, KEY_ADDR);

`ifdef INPUT_PORT_EVENT_EN
    logic [3:0] key_event_reg;
    logic [3:0] key_event_next;
    logic       unused_sw_next;

    assign unused_sw_next = ^sw_stable_next;

    // A press landing on the same edge as a clearing read survives (set wins).
    always_comb begin
        key_event_next = key_event_reg;
        if (rd_key) begin
            key_event_next = '0;
        end
        key_event_next = key_event_next | (key_stable & ~key_stable_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_event_reg <= '0;
        end else begin
            key_event_reg <= key_event_next;
        end
    end

    assign key_event_bits = key_event_reg;
`else
    logic unused_next;

    assign unused_next    = ^{sw_stable_next, key_stable_next};
    assign key_event_bits = 4'b0000;
`endif

    always_comb begin
        rd_valid_next = 1'b0;
        rd_data_next  = '0;
        if (rd_sw) begin
            rd_valid_next = 1'b1;
            rd_data_next  = {6'b0, sw_stable};
        end else if (rd_key) begin
            rd_valid_next = 1'b1;
            rd_data_next  = {8'b0, key_level, key_event_bits};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_data_reg  <= rd_data_next;
            rd_valid_reg <= rd_valid_next;
        end
    end

    assign bus.rd_data  = rd_data_reg;
    assign bus.rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_mmio_input_port.sv
// Directed bench for mmio_input_port with DEBOUNCE_CYCLES = 4; every bus cycle
// pushes its expected response to a scoreboard and checks it one edge later.
module tb_mmio_input_port;
    import mmio_input_port_pkg::*;

`ifdef INPUT_PORT_EVENT_EN
    localparam bit EV_EN = 1'b1;
`else
    localparam bit EV_EN = 1'b0;
`endif

    localparam logic [8:0] OTHER_ADDR = 9'h142;

    typedef struct packed {
        logic        v;
        logic [15:0] d;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [9:0] SW;
    logic [3:0] KEY;
    int         tests;
    int         fails;
    exp_t       sb_q[$];

    mmio_input_port_if bus ();

    mmio_input_port #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .SW   (SW),
        .KEY  (KEY),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] key_word(input logic [3:0] level, input logic [3:0] ev);
        return {8'h00, level, (EV_EN ? ev : 4'h0)};
    endfunction

    // One bus cycle: drive request, push expectation, check after the edge.
    task automatic step(input logic [1:0] cmd, input logic [8:0] addr, input logic rst,
                        input logic exp_v, input logic [15:0] exp_d, input string tag);
        exp_t e;
        bus.mem_cmd  = cmd;
        bus.mem_addr = addr;
        reset        = rst;
        sb_q.push_back('{v: exp_v, d: exp_d});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        tests++;
        assert (bus.rd_valid === e.v) else begin
            fails++;
            $error("FAIL %s rd_valid: got %b expected %b", tag, bus.rd_valid, e.v);
        end
        tests++;
        assert (bus.rd_data === e.d) else begin
            fails++;
            $error("FAIL %s rd_data: got %h expected %h", tag, bus.rd_data, e.d);
        end
        $display("[TB] %s cmd=%0d addr=%h rd_valid=%b rd_data=%h", tag, cmd, addr,
                 bus.rd_valid, bus.rd_data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(MNONE, 9'h000, 1'b0, 1'b0, 16'h0000, "idle");
    endtask

    task automatic rd_sw(input logic [15:0] exp_d, input string tag);
        step(MREAD, SW_ADDR_DEF, 1'b0, 1'b1, exp_d, tag);
    endtask

    task automatic rd_key(input logic [3:0] level, input logic [3:0] ev, input string tag);
        step(MREAD, KEY_ADDR_DEF, 1'b0, 1'b1, key_word(level, ev), tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tests        = 0;
        fails        = 0;
        reset        = 1'b1;
        SW           = 10'h000;
        KEY          = 4'hF;
        bus.mem_cmd  = MNONE;
        bus.mem_addr = 9'h000;

        for (int i = 0; i < 3; i++) step(MNONE, 9'h000, 1'b1, 1'b0, 16'h0000, "reset");
        rd_sw(16'h0000, "reset_sw");
        rd_key(4'h0, 4'h0, "reset_key");

        // Switch latency: value visible to a read issued 7 edges after change.
        SW = 10'h3FF;
        for (int i = 0; i < 6; i++) rd_sw(16'h0000, "sw_not_yet");
        rd_sw(16'h03FF, "sw_accepted");
        idle(1);

        // 3-cycle glitch rejected, 4-cycle pulse accepted.
        SW = 10'h000;
        idle(8);
        rd_sw(16'h0000, "sw_cleared");
        SW = 10'h001;
        idle(3);
        SW = 10'h000;
        idle(6);
        rd_sw(16'h0000, "glitch_rejected");
        SW = 10'h001;
        idle(4);
        SW = 10'h000;
        idle(2);
        rd_sw(16'h0001, "pulse4_accepted");
        idle(8);
        rd_sw(16'h0000, "pulse4_released");

        // Key press: event plus level, then read-to-clear.
        KEY = 4'b1011;
        idle(10);
        rd_key(4'h4, 4'h4, "key2_press");
        rd_key(4'h4, 4'h0, "key2_cleared");
        KEY = 4'hF;
        idle(8);
        rd_key(4'h0, 4'h0, "key2_release");

        // Read on the exact edge key_level[1] rises: set wins over clear.
        KEY = 4'b1101;
        idle(5);
        rd_key(4'h0, 4'h0, "key1_same_edge");
        rd_key(4'h2, 4'h2, "key1_next_read");
        rd_key(4'h2, 4'h0, "key1_cleared");

        // Writes and non-matching accesses have no response and no side effect.
        KEY = 4'hF;
        idle(8);
        rd_key(4'h0, 4'h0, "key1_release");
        KEY = 4'b1110;
        idle(8);
        step(MWRITE, KEY_ADDR_DEF, 1'b0, 1'b0, 16'h0000, "write_key");
        step(MWRITE, SW_ADDR_DEF, 1'b0, 1'b0, 16'h0000, "write_sw");
        step(MNONE, KEY_ADDR_DEF, 1'b0, 1'b0, 16'h0000, "none_key");
        step(MREAD, OTHER_ADDR, 1'b0, 1'b0, 16'h0000, "read_other");
        rd_key(4'h1, 4'h1, "key0_after_write");

        // Reset during a read and during debounce discards everything.
        KEY = 4'b0110;
        SW  = 10'h3FF;
        idle(2);
        step(MREAD, KEY_ADDR_DEF, 1'b1, 1'b0, 16'h0000, "reset_mid_read");
        rd_sw(16'h0000, "post_reset_sw");
        rd_key(4'h0, 4'h0, "post_reset_key");
        idle(8);
        rd_key(4'h9, 4'h9, "keys_relearned");
        rd_sw(16'h03FF, "sw_relearned");

        tests++;
        assert (sb_q.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
